uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive half of the board's serial link, paired with the existing `uart_tx`. It recovers 8N1 frames from the asynchronous `rx` pin, samples each bit at its centre, and presents each received byte as a one-cycle strobe. Framing errors are flagged without corrupting the last good byte. It sits between the FPGA RX pin and the host command/config logic.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `BAUD_DIV = CLK_FREQ/BAUD_RATE` (434 at defaults). `HALF_DIV = BAUD_DIV/2` (217), integer division. Legal range is 4 ≤ BAUD_DIV < 65536.

- `clk`  in  1  system clock. One clock domain; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  serial line, asynchronous to `clk`. Idle is high.
- `data_out`  out  8  last correctly framed byte. Held until the next good frame.
- `data_valid`  out  1  one-cycle pulse: `data_out` was updated this cycle.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `busy`  out  1  high while a frame is being received or recovered.

## Operation
- `rx` passes through a 2-flop synchronizer, `rx_s`. Both flops reset to 1, so reset never produces a false start.
- Counters:
  - 16-bit `baud_cnt`.
  - 3-bit `bit_idx`.
  - 8-bit shift register, filled LSB first: each new sample enters at bit 7 and the register shifts right.
- States:
  - IDLE
    - `busy`=0.
    - When `rx_s`=0: clear `baud_cnt`, go to START, `busy`=1.
  - START
    - Count to HALF_DIV-1, then sample `rx_s`.
    - If 0: clear `baud_cnt` and `bit_idx`, go to DATA.
    - If 1: glitch or false start; go to IDLE with no pulses.
  - DATA
    - Count to BAUD_DIV-1, sample `rx_s` into the shift register, clear `baud_cnt`.
    - After `bit_idx`==7 is sampled, go to STOP. Otherwise increment `bit_idx`.
  - STOP
    - Count to BAUD_DIV-1, sample `rx_s`.
    - If 1: load `data_out` from the shift register, pulse `data_valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data_out` unchanged, go to RECOVER.
  - RECOVER
    - Wait until `rx_s`=1, then go to IDLE.
    - A break (line held low) therefore yields exactly one `frame_err` and no further frames.
- IDLE is re-entered at mid-stop-bit. This gives half a bit time of slack, so back-to-back frames with one stop bit are received without loss.
- `data_valid` and `frame_err` are never high in the same cycle.
- Reset at any time (async) forces:
  - state IDLE
  - `data_out`=0x00
  - `data_valid`=0, `frame_err`=0, `busy`=0
  - counters 0, synchronizer flops 1
- A partial frame in progress at reset is discarded.

## Timing
- Let E be the first `clk` edge at which `rx_s`==0 in IDLE. The pin edge precedes E by 2–3 cycles of synchronizer delay.
- The START state is entered and `busy` is asserted at E.
- Start-bit check: edge E+HALF_DIV.
- Data bit i (i=0..7): sampled at edge E+HALF_DIV+(i+1)·BAUD_DIV.
- Stop sample: edge S = E+HALF_DIV+9·BAUD_DIV. At defaults, S = E+4123.
- At edge S (registered outputs, high for exactly one cycle):
  - `data_valid` or `frame_err` goes high.
  - `data_out` updates on the same edge as `data_valid`.
  - `busy` falls on that edge for a good frame. For a bad frame it falls when RECOVER exits.
- Receive latency from the pin falling edge to `data_valid` is about 9.5 bit times plus 2–3 cycles.
- Baud tolerance: frames are received correctly with up to ±2% rate mismatch between the transmitter and `BAUD_RATE`.

## Test plan
- Single byte: send 0xA5 at 115200 (defaults) → one `data_valid` at E+4123, `data_out`=0xA5, `frame_err` never high, `busy` low afterwards.
- Back-to-back: 0x00, 0xFF, 0x55 with one stop bit and no idle gap → three `data_valid` pulses with 0x00, 0xFF, 0x55 in order.
- Glitch: `rx` low for 100 cycles (< HALF_DIV=217), then high → no pulses, `busy` back to 0 by E+217, next 0x3C received correctly.
- Framing error: 0x81 with the stop bit driven low, then a 10-bit-time break, then 0x7E → exactly one `frame_err`, `data_out` holds its prior value during the break, then `data_valid` with 0x7E.
- Reset mid-frame: assert `rst_n`=0 during bit 4 of 0xC3 → all outputs 0 immediately, no pulse from the aborted frame, next 0x12 received correctly.
- Rate skew: the transmitter runs at 115200·1.02 and at 115200·0.98 sending 0x00–0xFF → all 256 bytes match, zero `frame_err`.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, one-cycle
// data_valid / frame_err strobes, and break recovery after a framing error.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DIV  = BAUD_DIV / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_e;

  state_e      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        busy_q;

  logic [15:0] baud_cnt_d;
  assign baud_cnt_d = baud_cnt_q + 16'd1;

  // Synchronizer resets to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two stages distinct; blocking would collapse them into one flop.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            baud_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        S_DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q   <= S_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit gives half a bit of slack for back-to-back frames.
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_RECOVER;
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        S_RECOVER: begin
          if (rx_s_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one default-rate instance for timing/framing cases,
// two fast-divider instances driven at +/-2% rate skew over all byte values.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam realtime CLK_HALF = 5.0;
  localparam realtime BT0      = 4340.0;          // 434 cycles at 10 ns
  localparam realtime BT_FAST  = 160.0 / 1.02;    // divider 16, transmitter 2% fast
  localparam realtime BT_SLOW  = 160.0 / 0.98;    // divider 16, transmitter 2% slow

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_skew_n = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [7:0] dout [3];
  logic [2:0] dv;
  logic [2:0] fe;
  logic [2:0] busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dv_cnt [3] = '{0, 0, 0};
  int fe_cnt [3] = '{0, 0, 0};
  int both_cnt = 0;
  int dv_cyc0 = 0;
  int busy_rise_cyc = 0;
  logic busy_prev0 = 1'b0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  always #(CLK_HALF) clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .frame_err(fe[0]), .busy(busy[0])
  );
  uart_rx #(.CLK_FREQ(1_843_200), .BAUD_RATE(115_200)) u_fast (
    .clk(clk), .rst_n(rst_skew_n), .rx(rx_line[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .frame_err(fe[1]), .busy(busy[1])
  );
  uart_rx #(.CLK_FREQ(1_843_200), .BAUD_RATE(115_200)) u_slow (
    .clk(clk), .rst_n(rst_skew_n), .rx(rx_line[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .frame_err(fe[2]), .busy(busy[2])
  );

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dv[k]) dv_cnt[k]++;
      if (fe[k]) fe_cnt[k]++;
      if (dv[k] && fe[k]) both_cnt++;
    end
    if (dv[0]) begin
      q0.push_back(dout[0]);
      dv_cyc0 = cyc;
    end
    if (dv[1]) q1.push_back(dout[1]);
    if (dv[2]) q2.push_back(dout[2]);
    if (busy[0] && !busy_prev0) busy_rise_cyc = cyc;
    busy_prev0 = busy[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_q0();
    if (q0.size() == 0) return 32'h100;
    return {24'd0, q0.pop_front()};
  endfunction

  task automatic send_frame(input int ln, input logic [7:0] b, input logic stop_v, input realtime bt);
    rx_line[ln] = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_line[ln] = b[i];
      #(bt);
    end
    rx_line[ln] = stop_v;
    #(bt);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed();
    int fall_cyc;
    int fe_base;
    logic [7:0] exp_b2b [3];
    exp_b2b = '{8'h00, 8'hFF, 8'h55};

    // Single byte with exact latency: E is the 3rd edge after the pin falls.
    align();
    fall_cyc = cyc;
    send_frame(0, 8'hA5, 1'b1, BT0);
    #(BT0);
    check("single_count", q0.size(), 1);
    check("single_data", dout[0], 8'hA5);
    check("single_latency", dv_cyc0 - fall_cyc, 3 + 4123);
    check("busy_rise", busy_rise_cyc - fall_cyc, 3);
    check("single_no_ferr", fe_cnt[0], 0);
    check("single_busy_low", busy[0], 1'b0);

    // Back-to-back frames, one stop bit, no idle gap.
    q0.delete();
    for (int i = 0; i < 3; i++) send_frame(0, exp_b2b[i], 1'b1, BT0);
    #(BT0);
    check("b2b_count", q0.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("b2b_%0d", i), pop_q0(), {24'd0, exp_b2b[i]});

    // Glitch shorter than half a bit: start check rejects it at E+217.
    q0.delete();
    fe_base = fe_cnt[0];
    align();
    fall_cyc = cyc;
    rx_line[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rx_line[0] = 1'b1;
    wait (cyc == fall_cyc + 219);
    @(negedge clk);
    check("glitch_busy_held", busy[0], 1'b1);
    @(negedge clk);
    check("glitch_busy_drop", busy[0], 1'b0);
    #(BT0);
    check("glitch_no_pulse", q0.size(), 0);
    send_frame(0, 8'h3C, 1'b1, BT0);
    #(BT0);
    check("after_glitch", pop_q0(), 32'h3C);
    check("glitch_no_ferr", fe_cnt[0], fe_base);

    // Framing error followed by a break: one frame_err, data_out held.
    q0.delete();
    fe_base = fe_cnt[0];
    send_frame(0, 8'h81, 1'b0, BT0);
    #(BT0 * 5);
    check("break_hold", dout[0], 8'h3C);
    check("break_busy", busy[0], 1'b1);
    check("break_ferr_once", fe_cnt[0], fe_base + 1);
    #(BT0 * 5);
    rx_line[0] = 1'b1;
    #(BT0 * 2);
    check("break_recovered", busy[0], 1'b0);
    check("break_ferr_total", fe_cnt[0], fe_base + 1);
    check("break_no_data", q0.size(), 0);
    send_frame(0, 8'h7E, 1'b1, BT0);
    #(BT0);
    check("after_break", pop_q0(), 32'h7E);

    // Reset during data bit 4: outputs clear immediately, frame discarded.
    q0.delete();
    fe_base = fe_cnt[0];
    align();
    fork
      send_frame(0, 8'hC3, 1'b1, BT0);
      begin
        #(BT0 * 5.5);
        rst_n = 1'b0;
        #1;
        check("rst_data", dout[0], 8'h00);
        check("rst_busy", busy[0], 1'b0);
        check("rst_valid", dv[0], 1'b0);
        check("rst_ferr", fe[0], 1'b0);
      end
    join
    #(BT0);
    rst_n = 1'b1;
    #(BT0);
    check("rst_no_pulse", q0.size(), 0);
    check("rst_no_ferr", fe_cnt[0], fe_base);
    send_frame(0, 8'h12, 1'b1, BT0);
    #(BT0);
    check("after_rst", pop_q0(), 32'h12);
    check("after_rst_out", dout[0], 8'h12);
  endtask

  task automatic run_skew(input int ln, input realtime bt);
    #(3.7 * ln);
    for (int b = 0; b < 256; b++) send_frame(ln, 8'(b), 1'b1, bt);
    #(bt * 2);
  endtask

  initial begin
    #35;
    check("reset_data", dout[0], 8'h00);
    check("reset_valid", dv[0], 1'b0);
    check("reset_ferr", fe[0], 1'b0);
    check("reset_busy", busy[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_skew_n = 1'b1;
    repeat (5) @(posedge clk);

    fork
      run_directed();
      run_skew(1, BT_FAST);
      run_skew(2, BT_SLOW);
    join

    check("skew_fast_count", q1.size(), 256);
    for (int i = 0; i < q1.size(); i++) check($sformatf("skew_fast_%0d", i), q1[i], i);
    check("skew_fast_ferr", fe_cnt[1], 0);
    check("skew_slow_count", q2.size(), 256);
    for (int i = 0; i < q2.size(); i++) check($sformatf("skew_slow_%0d", i), q2[i], i);
    check("skew_slow_ferr", fe_cnt[2], 0);
    check("valid_ferr_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
